intersection_sequencer: RTL

Phase sequencer and arbiter for a two-way (NS/EW) signalised intersection. It arbitrates green time between the two approaches and latches pedestrian button requests into walk grants. It handles emergency-vehicle preemption and applies run-time phase lengths. It drives the car-signal and walk outputs directly and sits above the per-approach lamp drivers.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/phase_timer.sv | 31 +++
 rtl/intersection_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection sequencer: lamp codes, phase
// encodings and phase classification.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    PH_ALL_RED_A = 3'd0,
    PH_NS_GREEN  = 3'd1,
    PH_NS_YELLOW = 3'd2,
    PH_ALL_RED_B = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5
  } phase_e;

  function automatic logic phase_is_green(input phase_e p);
    return (p == PH_NS_GREEN) || (p == PH_EW_GREEN);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: loads L-1 on phase entry (L=0 counts as 1), decrements
// each cycle unless frozen, and flags expiry when it reaches zero.
module phase_timer #(
  parameter int                 CNT_W     = 8,
  parameter logic [CNT_W-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             freeze,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= (len == '0) ? '0 : len - CNT_W'(1);
    end else if (!freeze && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/intersection_sequencer.sv
// Two-approach phase sequencer: normal NS/EW rotation with all-red separation,
// pedestrian walk grants and emergency-vehicle preemption.
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RESET_RED = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_green_ns,
  input  logic [CNT_W-1:0] cfg_green_ew,
  input  logic [CNT_W-1:0] cfg_yellow,
  input  logic [CNT_W-1:0] cfg_allred,
  input  logic [CNT_W-1:0] cfg_walk_min,
  input  logic             req_ped_ns,
  input  logic             req_ped_ew,
  input  logic             preempt_req,
  input  logic             preempt_dir,
  output logic [2:0]       signal_ns,
  output logic [2:0]       signal_ew,
  output logic             walk_ns,
  output logic             walk_ew,
  output logic [2:0]       phase,
  output logic             phase_start,
  output logic             preempt_active
);

  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_RED - 1);

  phase_e           phase_q, phase_d, tgt_green;
  logic             expire, enter, hold_now, preempt_d;
  logic             pend_ns, pend_ew, grant_ns, grant_ew;
  logic [CNT_W-1:0] phase_len, walk_len_ns, walk_len_ew;

  assign grant_ns    = pend_ns | req_ped_ns;
  assign grant_ew    = pend_ew | req_ped_ew;
  assign walk_len_ns = (cfg_green_ns > cfg_walk_min) ? cfg_green_ns : cfg_walk_min;
  assign walk_len_ew = (cfg_green_ew > cfg_walk_min) ? cfg_green_ew : cfg_walk_min;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tgt_green = PH_NS_GREEN;
    if (preempt_dir) tgt_green = PH_EW_GREEN;
  end

  assign hold_now = preempt_req && (phase_q == tgt_green);

  always_comb begin
    phase_d = phase_q;
    if (hold_now) begin
      phase_d = phase_q;
    end else if (preempt_active || (preempt_req && phase_is_green(phase_q))) begin
      // Released hold, or preempted away from the non-target green.
      phase_d = (phase_q == PH_NS_GREEN) ? PH_NS_YELLOW : PH_EW_YELLOW;
    end else if (expire) begin
      case (phase_q)
        PH_ALL_RED_A: phase_d = (preempt_req && preempt_dir)  ? PH_EW_GREEN : PH_NS_GREEN;
        PH_NS_GREEN:  phase_d = PH_NS_YELLOW;
        PH_NS_YELLOW: phase_d = PH_ALL_RED_B;
        PH_ALL_RED_B: phase_d = (preempt_req && !preempt_dir) ? PH_NS_GREEN : PH_EW_GREEN;
        PH_EW_GREEN:  phase_d = PH_EW_YELLOW;
        default:      phase_d = PH_ALL_RED_A;
      endcase
    end
  end

  assign enter     = (phase_d != phase_q);
  assign preempt_d = preempt_req && (phase_d == tgt_green);

  // A green entered under preemption grants no walk and keeps the pending flag.
  always_comb begin
    phase_len = cfg_allred;
    case (phase_d)
      PH_NS_GREEN:  phase_len = (grant_ns && !preempt_d) ? walk_len_ns : cfg_green_ns;
      PH_EW_GREEN:  phase_len = (grant_ew && !preempt_d) ? walk_len_ew : cfg_green_ew;
      PH_NS_YELLOW,
      PH_EW_YELLOW: phase_len = cfg_yellow;
      default:      phase_len = cfg_allred;
    endcase
  end

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (RESET_LOAD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (enter),
    .len    (phase_len),
    .freeze (hold_now),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= PH_ALL_RED_A;
      phase_start    <= 1'b1;
      preempt_active <= 1'b0;
      pend_ns        <= 1'b0;
      pend_ew        <= 1'b0;
      walk_ns        <= 1'b0;
      walk_ew        <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      phase_start    <= enter;
      preempt_active <= preempt_d;
      pend_ns <= (enter && phase_d == PH_NS_GREEN && !preempt_d) ? 1'b0 : grant_ns;
      pend_ew <= (enter && phase_d == PH_EW_GREEN && !preempt_d) ? 1'b0 : grant_ew;
      if (enter) begin
        walk_ns <= (phase_d == PH_NS_GREEN) && grant_ns && !preempt_d;
        walk_ew <= (phase_d == PH_EW_GREEN) && grant_ew && !preempt_d;
      end else begin
        walk_ns <= walk_ns && !(hold_now && !preempt_dir);
        walk_ew <= walk_ew && !(hold_now && preempt_dir);
      end
    end
  end

  always_comb begin
    signal_ns = LAMP_RED;
    signal_ew = LAMP_RED;
    case (phase_q)
      PH_NS_GREEN:  signal_ns = LAMP_GREEN;
      PH_NS_YELLOW: signal_ns = LAMP_YELLOW;
      PH_EW_GREEN:  signal_ew = LAMP_GREEN;
      PH_EW_YELLOW: signal_ew = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign phase = phase_q;

endmodule
